// File: rtl/pwm_multi_channel_pkg.sv
// Shared definitions for the multi-channel PWM: preload register address map
// and the write-address width helper.
package pwm_multi_channel_pkg;

    localparam int ADDR_PERIOD     = 32'd0;
    localparam int ADDR_CCR_BASE   = 32'd1;
    localparam int ADDR_DELAY_BASE = 32'd2;

    // Address space holds PERIOD plus a CCR/DELAY pair per channel.
    function automatic int pwm_addr_width(input int nch);
        return $clog2(32'd2 * nch + 32'd1);
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: compares the shared counter against the active CCR/DELAY
// window and registers the polarity-adjusted output.
module pwm_channel_cmp
    import pwm_multi_channel_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ch_en,
    input  logic             pol,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] ccr,
    input  logic [WIDTH-1:0] delay,
    output logic             pwm_out
);

    logic [WIDTH:0] end_s;
    logic           raw_s;
    logic           pwm_d;
    logic           pwm_q;

    // Raw level; END carries one extra bit so DELAY+CCR never truncates.
    always_comb begin
        end_s = {1'b0, delay} + {1'b0, ccr};
        raw_s = 1'b0;
        if (!enable || !ch_en) begin
            raw_s = 1'b0;
        end else if (ccr == '0) begin
            raw_s = 1'b0;
        end else if (ccr >= period) begin
            raw_s = 1'b1;
        end else if (delay >= period) begin
            raw_s = 1'b0;
        end else if (end_s <= {1'b0, period}) begin
            raw_s = (cnt >= delay) && ({1'b0, cnt} < end_s);
        end else begin
            raw_s = (cnt >= delay) || ({1'b0, cnt} < (end_s - {1'b0, period}));
        end
        pwm_d = raw_s ^ pol;
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared up-counter, update-event generation and a
// preload/active register file feeding NCH compare channels.
module pwm_multi_channel
    import pwm_multi_channel_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    localparam int AW    = pwm_addr_width(NCH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic [NCH-1:0]   CH_EN,
    input  logic [NCH-1:0]   POL,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic [WIDTH-1:0] CNT,
    output logic             UEV,
    output logic [NCH-1:0]   PWM_OUT
);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             uev_d, uev_q;
    logic             en_prev_d, en_prev_q;
    logic             en_rise_s, wrap_s, upd_s;

    logic [WIDTH-1:0] period_pre_d, period_pre_q;
    logic [WIDTH-1:0] period_act_d, period_act_q;
    logic [WIDTH-1:0] ccr_pre_d [NCH];
    logic [WIDTH-1:0] ccr_pre_q [NCH];
    logic [WIDTH-1:0] ccr_act_d [NCH];
    logic [WIDTH-1:0] ccr_act_q [NCH];
    logic [WIDTH-1:0] dly_pre_d [NCH];
    logic [WIDTH-1:0] dly_pre_q [NCH];
    logic [WIDTH-1:0] dly_act_d [NCH];
    logic [WIDTH-1:0] dly_act_q [NCH];

    // Counter and update event; a PERIOD of 0 or 1 wraps on every edge so
    // new preload values can still be picked up.
    always_comb begin
        en_rise_s = ENABLE & ~en_prev_q;
        wrap_s    = 1'b0;
        if (ENABLE && en_prev_q) begin
            if ((period_act_q <= WIDTH'(1)) || (cnt_q >= (period_act_q - WIDTH'(1)))) begin
                wrap_s = 1'b1;
            end else begin
                wrap_s = 1'b0;
            end
        end else begin
            wrap_s = 1'b0;
        end
        upd_s = en_rise_s | wrap_s;
        if (!ENABLE) begin
            cnt_d = '0;
        end else if (upd_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        uev_d     = upd_s;
        en_prev_d = ENABLE;
    end

    // Preload writes and preload-to-active transfer; active copies take the
    // pre-edge preload, so a write on the update edge waits a full period.
    always_comb begin
        if (WR_EN && (WR_ADDR == AW'(ADDR_PERIOD))) begin
            period_pre_d = WR_DATA;
        end else begin
            period_pre_d = period_pre_q;
        end
        if (upd_s) begin
            period_act_d = period_pre_q;
        end else begin
            period_act_d = period_act_q;
        end
        for (int k = 0; k < NCH; k++) begin
            if (WR_EN && (WR_ADDR == AW'(ADDR_CCR_BASE + 2 * k))) begin
                ccr_pre_d[k] = WR_DATA;
            end else begin
                ccr_pre_d[k] = ccr_pre_q[k];
            end
            if (WR_EN && (WR_ADDR == AW'(ADDR_DELAY_BASE + 2 * k))) begin
                dly_pre_d[k] = WR_DATA;
            end else begin
                dly_pre_d[k] = dly_pre_q[k];
            end
            if (upd_s) begin
                ccr_act_d[k] = ccr_pre_q[k];
                dly_act_d[k] = dly_pre_q[k];
            end else begin
                ccr_act_d[k] = ccr_act_q[k];
                dly_act_d[k] = dly_act_q[k];
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q        <= '0;
            uev_q        <= 1'b0;
            en_prev_q    <= 1'b0;
            period_pre_q <= '0;
            period_act_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                ccr_pre_q[k] <= '0;
                ccr_act_q[k] <= '0;
                dly_pre_q[k] <= '0;
                dly_act_q[k] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            uev_q        <= uev_d;
            en_prev_q    <= en_prev_d;
            period_pre_q <= period_pre_d;
            period_act_q <= period_act_d;
            for (int k = 0; k < NCH; k++) begin
                ccr_pre_q[k] <= ccr_pre_d[k];
                ccr_act_q[k] <= ccr_act_d[k];
                dly_pre_q[k] <= dly_pre_d[k];
                dly_act_q[k] <= dly_act_d[k];
            end
        end
    end

    assign CNT = cnt_q;
    assign UEV = uev_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH (WIDTH)
        ) u_cmp (
            .clk     (CLK),
            .rst_n   (RST_N),
            .enable  (ENABLE),
            .ch_en   (CH_EN[k]),
            .pol     (POL[k]),
            .cnt     (cnt_q),
            .period  (period_act_q),
            .ccr     (ccr_act_q[k]),
            .delay   (dly_act_q[k]),
            .pwm_out (PWM_OUT[k])
        );
    end

endmodule
